// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four byte requesters.
// Define UART_ARB_TIMEOUT_EN to bound the wait for tx_done and raise a sticky err.
module uart_tx_arbiter #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        tx_done,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] last_grant;
    logic [1:0] winner;
    logic [1:0] idx;
    logic [7:0] win_byte;

    // Scan downward so the closest requester after last_grant is assigned last.
    always_comb begin
        winner = 2'd0;
        idx    = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            idx = last_grant + 2'(i);
            if (req[idx]) begin
                winner = idx;
            end
        end
        win_byte = req_data[8*winner +: 8];
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] tmo_cnt;
`else
    assign err = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ack        <= 4'b0000;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            grant_id   <= 2'd0;
            busy       <= 1'b0;
            last_grant <= 2'd3;
`ifdef UART_ARB_TIMEOUT_EN
            err        <= 1'b0;
            tmo_cnt    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req && !tx_busy) begin
                        state      <= LAUNCH;
                        tx_data    <= win_byte;
                        grant_id   <= winner;
                        last_grant <= winner;
                        ack        <= 4'b0001 << winner;
                        tx_start   <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                LAUNCH: begin
                    ack      <= 4'b0000;
                    tx_start <= 1'b0;
                    state    <= WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                    tmo_cnt  <= '0;
`endif
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table plus grant scoreboard.
// Timeout checks run only when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        err;

    int comps = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [1:0]  id;
        logic [7:0]  byt;
        int          dly;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic [7:0] byt;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    uart_tx_arbiter #(.TIMEOUT_CYC(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .grant_id (grant_id),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        comps++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_grant(logic [1:0] id, logic [7:0] b);
        exp_t e;
        e.id  = id;
        e.byt = b;
        sb.push_back(e);
    endtask

    task automatic wait_start(output int n);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n++;
            if (tx_start) return;
        end
        comps++;
        fails++;
        $display("FAIL tx_start_timeout: got none in 12 cycles, expected a pulse");
        n = -1;
    endtask

    task automatic pulse_done();
        @(posedge clk) #1 tx_done = 1'b1;
        @(posedge clk) #1 tx_done = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk) #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
    endtask

    // Scoreboard: every tx_start must match the oldest expected grant.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (tx_start) begin
                if (sb.size() == 0) begin
                    comps++;
                    fails++;
                    $display("FAIL unexpected_tx_start: got grant %0d, expected none",
                             grant_id);
                end else begin
                    e = sb.pop_front();
                    chk("grant_id", 32'(grant_id), 32'(e.id));
                    chk("ack", 32'(ack), 32'(4'b0001 << e.id));
                    chk("tx_data", 32'(tx_data), 32'(e.byt));
                end
            end else if (ack != 4'b0000) begin
                chk("stray_ack", 32'(ack), 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        int n;
        int m;
        vecs[0] = '{4'b0100, 32'h11A52233, 2'd2, 8'hA5, 1};
        vecs[1] = '{4'b0101, 32'h44556677, 2'd0, 8'h77, 2};
        vecs[2] = '{4'b0101, 32'h8899AABB, 2'd2, 8'h99, 3};
        vecs[3] = '{4'b1000, 32'hC0FFEE01, 2'd3, 8'hC0, 1};
        vecs[4] = '{4'b0010, 32'h12345678, 2'd1, 8'h56, 4};
        vecs[5] = '{4'b0010, 32'h9ABCDEF0, 2'd1, 8'hDE, 2};
        vecs[6] = '{4'b1011, 32'h0F1E2D3C, 2'd3, 8'h0F, 5};
        vecs[7] = '{4'b0110, 32'hA1B2C3D4, 2'd1, 8'hC3, 1};

        rst = 1'b0;
        req = 4'b0000;
        req_data = 32'h0;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        #12;
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_tx_start", 32'(tx_start), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(posedge clk) #1;
            req = vecs[i].req;
            req_data = vecs[i].data;
            expect_grant(vecs[i].id, vecs[i].byt);
            wait_start(n);
            chk("latency", 32'(n), 32'd2);
            @(posedge clk) #1;
            req = 4'b0000;
            req_data = $urandom;
            @(negedge clk);
            chk("tx_data_hold", 32'(tx_data), 32'(vecs[i].byt));
            chk("busy_wait", 32'(busy), 32'h1);
            repeat (vecs[i].dly - 1) @(posedge clk);
            pulse_done();
            @(negedge clk);
            chk("busy_idle", 32'(busy), 32'h0);
        end

        // tx_done while idle with no request changes nothing
        pulse_done();
        repeat (3) begin
            @(negedge clk);
            chk("idle_done_busy", 32'(busy), 32'h0);
        end

        // tx_done during LAUNCH is ignored
        @(posedge clk) #1;
        req = 4'b0001;
        req_data = 32'h5A6B7C8D;
        expect_grant(2'd0, 8'h8D);
        wait_start(n);
        tx_done = 1'b1;
        @(posedge clk) #1;
        tx_done = 1'b0;
        req = 4'b0000;
        repeat (2) begin
            @(negedge clk);
            chk("launch_done_busy", 32'(busy), 32'h1);
        end
        pulse_done();
        @(negedge clk);
        chk("launch_done_idle", 32'(busy), 32'h0);

        // reset in WAIT_DONE aborts; requester 0 wins afterwards
        @(posedge clk) #1;
        req = 4'b1000;
        req_data = 32'hE1E2E3E4;
        expect_grant(2'd3, 8'hE1);
        wait_start(n);
        @(posedge clk) #1;
        req = 4'b1001;
        req_data = 32'h0102037F;
        @(posedge clk) #1 rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_tx_start", 32'(tx_start), 32'h0);
        chk("abort_ack", 32'(ack), 32'h0);
        repeat (2) @(posedge clk);
        expect_grant(2'd0, 8'h7F);
        @(negedge clk) rst = 1'b1;
        wait_start(n);
        chk("post_reset_latency", 32'(n), 32'd1);
        @(posedge clk) #1 req = 4'b0000;
        pulse_done();
        @(negedge clk);
        chk("post_reset_idle", 32'(busy), 32'h0);

        // tx_busy blocks grant in IDLE but is ignored once launched
        @(posedge clk) #1;
        tx_busy = 1'b1;
        req = 4'b0001;
        req_data = 32'h000000B6;
        repeat (4) begin
            @(negedge clk);
            chk("held_off_busy", 32'(busy), 32'h0);
        end
        expect_grant(2'd0, 8'hB6);
        @(posedge clk) #1 tx_busy = 1'b0;
        wait_start(n);
        chk("busy_release_latency", 32'(n), 32'd2);
        @(posedge clk) #1;
        req = 4'b0000;
        tx_busy = 1'b1;
        pulse_done();
        @(negedge clk);
        chk("busy_ignored_wait", 32'(busy), 32'h0);
        @(posedge clk) #1 tx_busy = 1'b0;

        // all four requesting continuously from reset
        do_reset();
        @(posedge clk) #1;
        req = 4'b1111;
        req_data = 32'hDDCCBBAA;
        expect_grant(2'd0, 8'hAA);
        expect_grant(2'd1, 8'hBB);
        expect_grant(2'd2, 8'hCC);
        expect_grant(2'd3, 8'hDD);
        expect_grant(2'd0, 8'hAA);
        for (int k = 0; k < 5; k++) begin
            wait_start(n);
            chk("rr_spacing", 32'(n), 32'd2);
            if (k == 4) begin
                @(posedge clk) #1 req = 4'b0000;
                repeat (4) @(posedge clk);
            end else begin
                repeat (5) @(posedge clk);
            end
            #1 tx_done = 1'b1;
            @(posedge clk) #1 tx_done = 1'b0;
        end
        @(negedge clk);
        chk("rr_idle", 32'(busy), 32'h0);

`ifdef UART_ARB_TIMEOUT_EN
        @(posedge clk) #1;
        req = 4'b0010;
        req_data = 32'h0000C900;
        expect_grant(2'd1, 8'hC9);
        wait_start(n);
        chk("err_before", 32'(err), 32'h0);
        @(posedge clk) #1 req = 4'b0000;
        m = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
            m++;
        end
        chk("timeout_cycles", 32'(m), 32'd8);
        chk("timeout_err", 32'(err), 32'h1);
        @(posedge clk) #1;
        req = 4'b0100;
        req_data = 32'h00D70000;
        expect_grant(2'd2, 8'hD7);
        wait_start(n);
        @(posedge clk) #1 req = 4'b0000;
        pulse_done();
        @(negedge clk);
        chk("err_sticky", 32'(err), 32'h1);
        chk("timeout_recover", 32'(busy), 32'h0);
`else
        chk("err_tied", 32'(err), 32'h0);
`endif

        repeat (3) @(negedge clk);
        chk("missing_tx_start", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64: max cycles WAIT_DONE waits for tx_done (timeout build only).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  per-requester byte request; held until matching ack.
REQ-005 req_data  input  32  requester i byte at bits [8i+7:8i]; stable while req[i] high.
REQ-006 ack  output  4  one-hot, one-cycle pulse: requester's byte accepted.
REQ-007 tx_start  output  1  one-cycle pulse launching the shared UART transmitter.
REQ-008 tx_data  output  8  byte presented to transmitter; valid from tx_start until the next grant.
REQ-009 tx_busy  input  1  shared transmitter busy (any owner).
REQ-010 tx_done  input  1  one-cycle pulse: transmitter finished stop bit.
REQ-011 grant_id  output  2  index of current/last granted requester.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 err  output  1  sticky timeout flag.

Function
REQ-014 FSM states SHALL be IDLE, LAUNCH, WAIT_DONE.
REQ-015 IDLE -> LAUNCH on an edge where req != 0 and tx_busy == 0; otherwise remain IDLE.
REQ-016 Winner SHALL be chosen round-robin: first set req bit searching upward from last_grant+1, wrapping 3 -> 0.
REQ-017 On IDLE -> LAUNCH: tx_data <= winner's byte, grant_id <= winner, last_grant <= winner, all registered.
REQ-018 In LAUNCH (exactly one cycle): tx_start = 1 and ack[grant_id] = 1; next state WAIT_DONE.
REQ-019 Latency: req sampled at edge k -> tx_start and ack high in the cycle following edge k.
REQ-020 WAIT_DONE -> IDLE on the edge where tx_done == 1; no grant in that same edge.
REQ-021 Minimum spacing between consecutive tx_start pulses SHALL be 3 cycles (LAUNCH, >=1 WAIT_DONE, IDLE).
REQ-022 req sampled in IDLE only; a req still high the cycle after its ack SHALL be treated as a new request.
REQ-023 req/req_data changes after ack SHALL not affect tx_data.
REQ-024 tx_done outside WAIT_DONE SHALL be ignored.
REQ-025 tx_busy SHALL be ignored in LAUNCH and WAIT_DONE.
REQ-026 A single requester requesting continuously SHALL be granted every transaction if no other req bit is set.
REQ-027 With all four requesting continuously, grants SHALL cycle 0,1,2,3,0,...

Reset
REQ-028 On rst low, asynchronously: state IDLE, ack 0, tx_start 0, tx_data 8'h00, grant_id 2'd0, busy 0, err 0, last_grant 2'd3, timeout counter 0.
REQ-029 Reset mid-transaction SHALL abort without issuing ack or tx_start; requester 0 has highest priority after release.
REQ-030 Leaving reset SHALL be synchronous to clk; first grant no earlier than the first edge with rst high.

Configuration
REQ-031 Macro UART_ARB_TIMEOUT_EN defined: counter clears on LAUNCH, increments each WAIT_DONE cycle; if it reaches TIMEOUT_CYC-1 without tx_done, next state IDLE and err set to 1 until reset; tx_done on that same edge takes priority (no err).
REQ-032 Macro undefined: no counter, WAIT_DONE waits indefinitely for tx_done, err tied 0, TIMEOUT_CYC unused.

Verification
REQ-033 Reset release, req=4'b0100, req_data byte2=8'hA5 -> next cycle tx_start=1, ack=4'b0100, tx_data=8'hA5, grant_id=2; no further tx_start before tx_done.
REQ-034 req=4'b1111 held, tx_done 5 cycles after each tx_start -> grant order 0,1,2,3,0 with matching ack and bytes.
REQ-035 tx_busy=1 with req=4'b0001 -> no grant; tx_busy falls -> tx_start next-but-one cycle.
REQ-036 Assert rst low in WAIT_DONE -> immediately busy=0, state IDLE; after release, req=4'b1001 -> requester 0 granted first.
REQ-037 UART_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, tx_done never pulsed -> return to IDLE after 8 WAIT_DONE cycles, err=1 sticky, next req granted normally.
REQ-038 tx_done pulsed while IDLE with req=0 -> no state change, no outputs.
